// File: rtl/output_decimator_pkg.sv
//----------------------------------------------------------------------------
// output_decimator_pkg
// Shared constants and types for the output decimator slice.
//   DEF_*            default widths and fixed-point formats of the datapath
//   decim_state_t    accumulation FSM states
//   round_shift()    right-shift that takes a block sum back to the output
//                    fixed-point format (divide by N and drop fraction bits)
//----------------------------------------------------------------------------
`timescale 1ns/1ps
package output_decimator_pkg;

   localparam int DEF_WORDLENGTH            = 14;
   localparam int DEF_FRACTIONAL_LENGTH     = 6;
   localparam int DEF_DECIM_LOG2            = 2;
   localparam int DEF_OUT_WORDLENGTH        = 10;
   localparam int DEF_OUT_FRACTIONAL_LENGTH = 2;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ACCUM = 1'b1
   } decim_state_t;

   // Dividing by N and dropping the surplus fraction bits are both plain
   // right shifts, so they collapse into one shift amount.
   function automatic int round_shift(input int decim_log2,
                                      input int frac_len,
                                      input int out_frac_len);
      return decim_log2 + frac_len - out_frac_len;
   endfunction

endpackage

// File: rtl/output_decimator_fifo.sv
//----------------------------------------------------------------------------
// skid_fifo2
// Two-entry FIFO carrying a data word plus a one-bit user flag.
//   clk, arst_n          clock, asynchronous active-low reset
//   s_valid/s_ready      write side; s_ready is a flop (no path from m_ready)
//   s_data/s_user        write payload
//   m_valid/m_ready      read side
//   m_data/m_user        head entry, stable while m_valid && !m_ready
//----------------------------------------------------------------------------
`timescale 1ns/1ps
module skid_fifo2 #(
   parameter int DATA_W = 10
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_user,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_user
);

   logic [DATA_W-1:0] data_mem [2];
   logic [1:0]        user_mem;
   logic              wr_ptr;
   logic              rd_ptr;
   logic [1:0]        level;
   logic [1:0]        level_next;
   logic              push;
   logic              pop;

   assign push    = s_valid && s_ready;
   assign pop     = m_valid && m_ready;
   assign m_valid = (level != 2'd0);
   assign m_data  = data_mem[rd_ptr];
   assign m_user  = user_mem[rd_ptr];

   // Occupancy only moves when exactly one of push/pop happens; a
   // simultaneous push and pop leaves it where it is.
   always_comb begin
      level_next = level;
      if (push && !pop) begin
         level_next = level + 2'd1;
      end else if (pop && !push) begin
         level_next = level - 2'd1;
      end
   end

   // Storage, pointers and the registered ready. Ready is computed from the
   // next occupancy so it is already correct on the cycle after the change;
   // it stays low through reset and rises on the first edge afterwards.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         data_mem[0] <= '0;
         data_mem[1] <= '0;
         user_mem    <= '0;
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         level       <= 2'd0;
         s_ready     <= 1'b0;
      end else begin
         if (push) begin
            data_mem[wr_ptr] <= s_data;
            user_mem[wr_ptr] <= s_user;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         level   <= level_next;
         s_ready <= (level_next != 2'd2);
      end
   end

endmodule

// File: rtl/output_decimator.sv
//----------------------------------------------------------------------------
// output_decimator
// Sums blocks of N = 2^DECIM_LOG2 signed samples, rounds the sum (half up)
// to the output fixed-point format, saturates it and queues it in a
// two-entry output FIFO.
//   clk, arst_n                   clock, asynchronous active-low reset
//   clr                           drop the partially accumulated block
//   s_tdata/s_tvalid/s_tready     input samples, Q(W-F).F signed
//   m_tdata/m_tuser/m_tvalid/
//   m_tready                      output words, m_tuser = saturated
//----------------------------------------------------------------------------
`timescale 1ns/1ps
module output_decimator
   import output_decimator_pkg::*;
#(
   parameter int WORDLENGTH            = DEF_WORDLENGTH,
   parameter int FRACTIONAL_LENGTH     = DEF_FRACTIONAL_LENGTH,
   parameter int DECIM_LOG2            = DEF_DECIM_LOG2,
   parameter int OUT_WORDLENGTH        = DEF_OUT_WORDLENGTH,
   parameter int OUT_FRACTIONAL_LENGTH = DEF_OUT_FRACTIONAL_LENGTH
) (
   input  logic                      clk,
   input  logic                      arst_n,
   input  logic                      clr,
   input  logic [WORDLENGTH-1:0]     s_tdata,
   input  logic                      s_tvalid,
   output logic                      s_tready,
   output logic [OUT_WORDLENGTH-1:0] m_tdata,
   output logic                      m_tuser,
   output logic                      m_tvalid,
   input  logic                      m_tready
);

   localparam int ACC_W = WORDLENGTH + DECIM_LOG2 + 1;
   localparam int SHIFT = round_shift(DECIM_LOG2, FRACTIONAL_LENGTH,
                                      OUT_FRACTIONAL_LENGTH);
   localparam int N     = 1 << DECIM_LOG2;

   localparam logic [DECIM_LOG2-1:0] LAST_COUNT = DECIM_LOG2'(N - 1);

   // Rounding and clamping run one bit wider than the accumulator so the
   // half-LSB offset can never wrap a large positive sum negative.
   localparam logic signed [ACC_W:0] ROUND_HALF =
      {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);
   localparam logic signed [ACC_W:0] OUT_MAX =
      {{(ACC_W - OUT_WORDLENGTH + 2){1'b0}}, {(OUT_WORDLENGTH - 1){1'b1}}};
   localparam logic signed [ACC_W:0] OUT_MIN =
      {{(ACC_W - OUT_WORDLENGTH + 2){1'b1}}, {(OUT_WORDLENGTH - 1){1'b0}}};

   decim_state_t              state;
   decim_state_t              next_state;
   logic [DECIM_LOG2-1:0]     count;
   logic signed [ACC_W-1:0]   acc;
   logic signed [ACC_W-1:0]   sample_ext;
   logic signed [ACC_W-1:0]   sum_next;
   logic signed [ACC_W:0]     sum_round;
   logic signed [ACC_W:0]     sum_shift;
   logic [OUT_WORDLENGTH-1:0] sat_data;
   logic                      sat_flag;
   logic                      accept;
   logic                      last_sample;
   logic                      push;
   logic                      acc_clear;
   logic                      acc_load;

   assign accept      = s_tvalid && s_tready;
   assign last_sample = accept && (count == LAST_COUNT);
   assign sample_ext  = {{(ACC_W - WORDLENGTH){s_tdata[WORDLENGTH-1]}}, s_tdata};
   assign sum_next    = acc + sample_ext;
   assign sum_round   = {sum_next[ACC_W-1], sum_next} + ROUND_HALF;
   assign sum_shift   = sum_round >>> SHIFT;

   // The completed block sum goes straight through rounding and clamping
   // into the FIFO, so the word is visible one cycle after the last sample.
   always_comb begin
      sat_data = sum_shift[OUT_WORDLENGTH-1:0];
      sat_flag = 1'b0;
      if (sum_shift > OUT_MAX) begin
         sat_data = OUT_MAX[OUT_WORDLENGTH-1:0];
         sat_flag = 1'b1;
      end else if (sum_shift < OUT_MIN) begin
         sat_data = OUT_MIN[OUT_WORDLENGTH-1:0];
         sat_flag = 1'b1;
      end
   end

   // Accumulation FSM state register.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next state: clr always wins; otherwise a block opens on its first
   // sample and closes on its N-th.
   always_comb begin
      next_state = state;
      if (clr) begin
         next_state = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:  if (accept && !last_sample) next_state = ST_ACCUM;
            ST_ACCUM: if (last_sample)            next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
         endcase
      end
   end

   // Datapath controls. A sample arriving together with clr is dropped
   // along with the partial block; the last sample of a block pushes the
   // result and restarts the count with no idle cycle in between.
   always_comb begin
      push      = 1'b0;
      acc_clear = 1'b0;
      acc_load  = 1'b0;
      if (clr) begin
         acc_clear = 1'b1;
      end else if (accept) begin
         if (last_sample) begin
            push      = 1'b1;
            acc_clear = 1'b1;
         end else begin
            acc_load = 1'b1;
         end
      end
   end

   // Running sum and sample count of the open block.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         acc   <= '0;
         count <= '0;
      end else if (acc_clear) begin
         acc   <= '0;
         count <= '0;
      end else if (acc_load) begin
         acc   <= sum_next;
         count <= count + 1'b1;
      end
   end

   // Input ready comes from the FIFO's registered ready, so a block can
   // only complete when there is room for its result.
   skid_fifo2 #(
      .DATA_W (OUT_WORDLENGTH)
   ) u_fifo (
      .clk     (clk),
      .arst_n  (arst_n),
      .s_valid (push),
      .s_ready (s_tready),
      .s_data  (sat_data),
      .s_user  (sat_flag),
      .m_valid (m_tvalid),
      .m_ready (m_tready),
      .m_data  (m_tdata),
      .m_user  (m_tuser)
   );

endmodule
